// File: rtl/sd_dfs_ctrl_pkg.sv
// ============================================================================
// Package : sd_pkg
// Shared tree geometry and controller state encoding for the sphere decoder.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package sd_pkg;

    localparam int NUM_LVL = 4;
    localparam int SYM_W   = 3;
    localparam int LVL_W   = 2;

    localparam logic [SYM_W-1:0] SYM_MAX  = 3'd7;
    localparam logic [LVL_W-1:0] ROOT_LVL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sd_dfs_ctrl_ascend_find.sv
// ============================================================================
// Module  : sd_ascend_find
// Finds the lowest level at or above the current one with an unexhausted symbol.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sd_ascend_find
    import sd_pkg::*;
(
    input  logic [LVL_W-1:0]              i_lvl,
    input  logic [NUM_LVL-1:0][SYM_W-1:0] i_s,
    output logic [LVL_W-1:0]              o_lvl,
    output logic                          o_exhausted
);

    // Scanning root-down lets the last hit win, i.e. the lowest qualifying level.
    always_comb begin
        o_lvl       = ROOT_LVL;
        o_exhausted = 1'b1;
        for (int i = NUM_LVL - 1; i >= 0; i--) begin
            if ((i >= int'(i_lvl)) && (i_s[i] != SYM_MAX)) begin
                o_lvl       = LVL_W'(i);
                o_exhausted = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_dfs_ctrl.sv
// ============================================================================
// Module  : sd_dfs_ctrl
// Radius-pruned depth-first sphere-decoding controller, one tree node per clock.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sd_dfs_ctrl
    import sd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 13
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Radius_init,
    input  logic [WIDTH-1:0] Cost_in,
    output logic [SYM_W-1:0] S_0,
    output logic [SYM_W-1:0] S_1,
    output logic [SYM_W-1:0] S_2,
    output logic [SYM_W-1:0] S_3,
    output logic [LVL_W-1:0] Lvl,
    output logic             Busy,
    output logic             OutputReady,
    output logic [SYM_W-1:0] Best_S_0,
    output logic [SYM_W-1:0] Best_S_1,
    output logic [SYM_W-1:0] Best_S_2,
    output logic [SYM_W-1:0] Best_S_3,
    output logic [WIDTH-1:0] Best_cost,
    output logic             Found,
    output logic [CNT_W-1:0] NodeCount
);

    state_t                        r_state;
    logic [NUM_LVL-1:0][SYM_W-1:0] r_s;
    logic [NUM_LVL-1:0][SYM_W-1:0] r_best_s;
    logic [LVL_W-1:0]              r_lvl;
    logic [WIDTH-1:0]              r_radius;
    logic [WIDTH-1:0]              r_best_cost;
    logic                          r_found;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_busy;
    logic                          r_ready;

    logic                          w_accept;
    logic [LVL_W-1:0]              w_lvl_dn;
    logic [LVL_W-1:0]              w_asc_lvl;
    logic                          w_exhausted;

    // Ties with the radius are pruned, hence strict less-than.
    assign w_accept = (Cost_in < r_radius);
    assign w_lvl_dn = r_lvl - 2'd1;

    sd_ascend_find u_ascend (
        .i_lvl       (r_lvl),
        .i_s         (r_s),
        .o_lvl       (w_asc_lvl),
        .o_exhausted (w_exhausted)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_lvl       <= ROOT_LVL;
            r_radius    <= '1;
            r_best_s    <= '0;
            r_best_cost <= '1;
            r_found     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_radius    <= Radius_init;
                        r_lvl       <= ROOT_LVL;
                        r_s         <= '0;
                        r_best_s    <= '0;
                        r_best_cost <= '1;
                        r_found     <= 1'b0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= EVAL;
                    end
                end
                EVAL: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_accept && (r_lvl != '0)) begin
                        r_lvl           <= w_lvl_dn;
                        r_s[w_lvl_dn]   <= '0;
                    end else begin
                        if (w_accept) begin
                            r_radius    <= Cost_in;
                            r_best_s    <= r_s;
                            r_best_cost <= Cost_in;
                            r_found     <= 1'b1;
                        end
                        if (w_exhausted) begin
                            r_ready <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_s[w_asc_lvl] <= r_s[w_asc_lvl] + 3'd1;
                            r_lvl          <= w_asc_lvl;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign S_0         = r_s[0];
    assign S_1         = r_s[1];
    assign S_2         = r_s[2];
    assign S_3         = r_s[3];
    assign Lvl         = r_lvl;
    assign Busy        = r_busy;
    assign OutputReady = r_ready;
    assign Best_S_0    = r_best_s[0];
    assign Best_S_1    = r_best_s[1];
    assign Best_S_2    = r_best_s[2];
    assign Best_S_3    = r_best_s[3];
    assign Best_cost   = r_best_cost;
    assign Found       = r_found;
    assign NodeCount   = r_cnt;

endmodule

`default_nettype wire
